ctle_sample_picker: RTL and testbench

- Sits directly downstream of the CTLE interpolating model.
- Each model step delivers four equally spaced waveform points out_0..out_3 over a step of duration dt (point k at offset k*dt/3).
- This block tracks absolute time against a fixed sampling period. Whenever a sampling instant falls inside a step, it picks the nearest of the four points and queues it into a small FIFO with a valid/ready interface.
- Output feeds the downstream slicer/checker.

---
 rtl/ctle_pkg.sv | 39 +++
 rtl/ctle_sample_fifo.sv | 67 ++++++
 rtl/ctle_sample_picker.sv | 107 ++++++++++
 tb/tb_ctle_sample_picker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctle_pkg.sv
//------------------------------------------------------------------------------
// ctle_pkg : shared types, constants and nearest-point helper for the picker
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ctle_pkg;

  localparam int CTLE_WIDTH = 18;
  localparam int CTLE_TW    = 24;
  localparam int N_POINTS   = 4;
  localparam int PICK_W     = CTLE_WIDTH + 2;

  typedef logic signed [CTLE_WIDTH-1:0] sample_t;
  typedef logic [CTLE_TW-1:0]           time_t;
  typedef logic [1:0]                   pick_idx_t;

  typedef struct packed {
    sample_t   data;
    pick_idx_t idx;
  } pick_t;

  // Points sit at 0, dt/3, 2dt/3, dt; thresholds at their midpoints, scaled by 6.
  function automatic pick_idx_t nearest_idx(input time_t off, input time_t dt);
    logic [CTLE_TW+2:0] off_x, dt_x, off6, dt3, dt5;
    off_x = {3'b000, off};
    dt_x  = {3'b000, dt};
    off6  = (off_x << 2) + (off_x << 1);
    dt3   = (dt_x << 1) + dt_x;
    dt5   = (dt_x << 2) + dt_x;
    if (off6 < dt_x)     return 2'd0;
    else if (off6 < dt3) return 2'd1;
    else if (off6 < dt5) return 2'd2;
    else                 return 2'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ctle_sample_fifo.sv
//------------------------------------------------------------------------------
// ctle_sample_fifo : first-word-fall-through FIFO of picked samples
// Revision         : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctle_sample_fifo
  import ctle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [PICK_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [PICK_W-1:0] head_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pick_t         mem_q [DEPTH];
  pick_t         last_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          w_push;
  logic          w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // When drained, the head keeps showing the most recently popped entry.
  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        last_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctle_sample_picker.sv
//------------------------------------------------------------------------------
// ctle_sample_picker : picks the nearest CTLE point at each sampling instant
// Revision           : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctle_sample_picker
  import ctle_pkg::*;
#(
  parameter int WIDTH   = CTLE_WIDTH,
  parameter int TW      = CTLE_TW,
  parameter int T_SAMP  = 100,
  parameter int T_PHASE = 0,
  parameter int DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [TW-1:0]           dt,
  input  logic signed [WIDTH-1:0] in_0,
  input  logic signed [WIDTH-1:0] in_1,
  input  logic signed [WIDTH-1:0] in_2,
  input  logic signed [WIDTH-1:0] in_3,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [1:0]              out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             sample_count,
  output logic                    err_overrun
);

  logic [TW:0] t_rem_q;
  logic [TW:0] t_rem_d;
  logic [TW:0] w_dt_ext;
  logic [TW:0] w_wrap;
  logic        w_accept;
  logic        w_hit;
  logic        w_full;
  logic        w_empty;
  pick_idx_t   w_idx;
  sample_t     w_pts [N_POINTS];
  pick_t       w_pick;
  pick_t       w_head;
  logic [15:0] sample_count_q;
  logic        err_overrun_q;

  assign in_ready = !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_dt_ext = {1'b0, dt};
  assign w_hit    = (t_rem_q < w_dt_ext);

  // Only consulted on a hit, where t_rem < dt guarantees the top bit is clear.
  assign w_idx    = nearest_idx(t_rem_q[TW-1:0], dt);

  assign w_pts[0] = in_0;
  assign w_pts[1] = in_1;
  assign w_pts[2] = in_2;
  assign w_pts[3] = in_3;

  assign w_pick.data = w_pts[w_idx];
  assign w_pick.idx  = w_idx;

  assign w_wrap = t_rem_q + (TW+1)'(T_SAMP);

  always_comb begin
    t_rem_d = t_rem_q;
    if (w_accept) begin
      if (w_hit) t_rem_d = (w_wrap > w_dt_ext) ? (w_wrap - w_dt_ext) : '0;
      else       t_rem_d = t_rem_q - w_dt_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_rem_q        <= (TW+1)'(T_PHASE);
      sample_count_q <= '0;
      err_overrun_q  <= 1'b0;
    end else begin
      t_rem_q <= t_rem_d;
      if (w_accept && w_hit) sample_count_q <= sample_count_q + 16'd1;
      if (w_accept && (w_dt_ext > (TW+1)'(T_SAMP))) err_overrun_q <= 1'b1;
    end
  end

  ctle_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_accept && w_hit),
    .push_data_i (w_pick),
    .pop_i       (out_ready),
    .head_o      (w_head),
    .empty_o     (w_empty),
    .full_o      (w_full)
  );

  assign out_data     = w_head.data;
  assign out_idx      = w_head.idx;
  assign out_valid    = !w_empty;
  assign sample_count = sample_count_q;
  assign err_overrun  = err_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ctle_sample_picker.sv
//------------------------------------------------------------------------------
// tb_ctle_sample_picker : directed and random steps against an absolute-time model
// Revision              : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctle_sample_picker;

  localparam int W  = 18;
  localparam int TW = 24;
  localparam int TS = 100;
  localparam int TP = 0;
  localparam int D  = 4;

  logic          clk;
  logic          rst_n;
  logic [TW-1:0] dt;
  logic [W-1:0]  in_0, in_1, in_2, in_3;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [1:0]    out_idx;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   sample_count;
  logic          err_overrun;

  ctle_sample_picker #(
    .WIDTH (W), .TW (TW), .T_SAMP (TS), .T_PHASE (TP), .DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dt           (dt),
    .in_0         (in_0),
    .in_1         (in_1),
    .in_2         (in_2),
    .in_3         (in_3),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sample_count (sample_count),
    .err_overrun  (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: absolute time of step start and of the next sampling instant.
  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   k;
  } ent_t;

  longint       m_t;
  longint       m_s;
  ent_t         q[$];
  logic [W-1:0] last_d;
  logic [1:0]   last_k;
  int           m_cnt;
  bit           m_err;
  bit           rnd_ready;
  int           checks;
  int           errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t    = 0;
    m_s    = TP;
    q.delete();
    last_d = '0;
    last_k = '0;
    m_cnt  = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input longint dtv, input logic [W-1:0] p0, p1, p2, p3);
    longint off;
    longint k;
    ent_t   e;
    if (m_s - m_t < dtv) begin
      off = m_s - m_t;
      k   = (6 * off + dtv) / (2 * dtv);
      if (k > 3) k = 3;
      case (k)
        0:       e.d = p0;
        1:       e.d = p1;
        2:       e.d = p2;
        default: e.d = p3;
      endcase
      e.k = 2'(k);
      q.push_back(e);
      m_cnt = (m_cnt + 1) % 65536;
      m_s   = (m_s + TS > m_t + dtv) ? m_s + TS : m_t + dtv;
    end
    if (dtv > TS) m_err = 1;
    m_t = m_t + dtv;
  endtask

  task automatic check_state();
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < D));
    check("sample_count", 64'(sample_count), 64'(m_cnt));
    check("err_overrun", 64'(err_overrun), 64'(m_err));
    if (q.size() == 0) begin
      check("hold_data", 64'(out_data), 64'(last_d));
      check("hold_idx", 64'(out_idx), 64'(last_k));
    end
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic cycle(output bit acc);
    bit   pop;
    ent_t e;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    acc = in_valid && (q.size() < D);
    pop = out_ready && (q.size() > 0);
    if (pop) begin
      check("pop_data", 64'(out_data), 64'(q[0].d));
      check("pop_idx", 64'(out_idx), 64'(q[0].k));
    end
    @(posedge clk);
    if (pop) begin
      e      = q.pop_front();
      last_d = e.d;
      last_k = e.k;
    end
    if (acc) model_step(longint'(dt), in_0, in_1, in_2, in_3);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  task automatic offer(input longint dtv, input logic [W-1:0] p0, p1, p2, p3);
    bit acc;
    int n;
    dt = TW'(dtv); in_0 = p0; in_1 = p1; in_2 = p2; in_3 = p3;
    in_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 64) begin
      cycle(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL offer_timeout observed=not_accepted expected=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic async_reset();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_state();
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    checks = 0; errors = 0; rnd_ready = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; dt = '0;
    in_0 = '0; in_1 = '0; in_2 = '0; in_3 = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_state();
    check("reset_data", 64'(out_data), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Nearest-point walk through successive dt=40 steps
    offer(40, 18'd10, 18'd20, 18'd30, 18'd40);
    offer(40, 18'd50, 18'd60, 18'd70, 18'd80);
    offer(40, 18'd90, 18'd100, 18'd110, 18'd120);
    idle(3);

    // Fill with the consumer stalled; fifth step must be held
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(100, 18'(i*4+1), 18'(i*4+2), 18'(i*4+3), 18'(i*4+4));
    dt = 24'd100; in_0 = 18'd91; in_1 = 18'd92; in_2 = 18'd93; in_3 = 18'd94;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);
    out_ready = 1'b1;
    offer(100, 18'd91, 18'd92, 18'd93, 18'd94);
    idle(6);

    // Zero-length steps leave the time tracker alone
    for (int i = 0; i < 10; i++) offer(0, 18'h3ffff, 18'h3fffe, 18'h3fffd, 18'h3fffc);
    offer(40, 18'd5, 18'd6, 18'd7, 18'd8);
    idle(3);

    // Overrun with t_rem = 0
    async_reset();
    offer(150, 18'd111, 18'd222, 18'd333, 18'd444);
    offer(40, 18'd1, 18'd2, 18'd3, 18'd4);
    offer(60, 18'd11, 18'd12, 18'd13, 18'd14);
    idle(3);

    // Random traffic with random backpressure
    async_reset();
    rnd_ready = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else offer(longint'($urandom_range(0, 130)), 18'($urandom), 18'($urandom),
                 18'($urandom), 18'($urandom));
    end
    rnd_ready = 0;
    out_ready = 1'b1;
    idle(6);

    // Asynchronous reset with a full FIFO, then the phase restarts
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(100, 18'd7, 18'd8, 18'd9, 18'd10);
    async_reset();
    out_ready = 1'b1;
    offer(40, 18'd21, 18'd22, 18'd23, 18'd24);
    offer(40, 18'd31, 18'd32, 18'd33, 18'd34);
    offer(40, 18'd41, 18'd42, 18'd43, 18'd44);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
